// File: rtl/addsub_pkg.sv
// Shared types and constants for the accumulating adder/subtractor stage.
package addsub_pkg;

  localparam int unsigned DW = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic [DW-1:0] SAT_HI = 4'hF;
  localparam logic [DW-1:0] SAT_LO = 4'h0;

  // One registered result together with its flags.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic          sat;
  } result_t;

  // Two's-complement overflow of a - b (sub) or a + b (add).
  function automatic logic calc_ovf(input logic          mode,
                                    input logic [DW-1:0] a,
                                    input logic [DW-1:0] b,
                                    input logic [DW-1:0] r);
    logic same_sign;
    same_sign = (a[DW-1] == b[DW-1]);
    if (mode == MODE_SUB) same_sign = !same_sign;
    return same_sign && (r[DW-1] != a[DW-1]);
  endfunction

endpackage

// File: rtl/adder_sub.sv
// 4-bit ripple-carry adder/subtractor: out = a + b (mode=0) or a - b (mode=1).
module adder_sub
  import addsub_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          mode,
  output logic [DW-1:0] out,
  output logic          cout
);

  logic [DW-1:0] b_eff;
  logic [DW:0]   carry;

  // Subtraction is a + ~b + 1, so the carry-in doubles as the "+1".
  assign b_eff    = b ^ {DW{mode}};
  assign carry[0] = mode;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign out[i]     = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = carry[DW];

endmodule

// File: rtl/addsub_acc.sv
// Handshaked accumulator stage around adder_sub: load / add / subtract with
// optional unsigned saturation, result held in a one-entry valid/ready register.
module addsub_acc
  import addsub_pkg::*;
#(
  parameter logic [DW-1:0] INIT = 4'h0,
  parameter bit            SAT  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] b,
  input  logic          mode,
  input  logic          clr,
  output logic [DW-1:0] acc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_cout,
  output logic          out_ovf,
  output logic          out_zero,
  output logic          out_sat
);

  logic [DW-1:0] acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  result_t       res_q, res_d;

  logic [DW-1:0] raw_sum;
  logic          raw_cout;
  logic          accept;

  adder_sub u_adder_sub (
    .a    (acc_q),
    .b    (b),
    .mode (mode),
    .out  (raw_sum),
    .cout (raw_cout)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the ifs can leave a value unassigned and infer a latch.
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      out_valid_d = 1'b1;
      if (clr) begin
        res_d.data = b;
        res_d.cout = 1'b0;
        res_d.ovf  = 1'b0;
        res_d.sat  = 1'b0;
      end else begin
        res_d.data = raw_sum;
        res_d.cout = raw_cout;
        res_d.ovf  = calc_ovf(mode, acc_q, b, raw_sum);
        res_d.sat  = 1'b0;
        // Add with carry overflowed the top; sub without carry borrowed.
        if (SAT) begin
          if (mode == MODE_ADD && raw_cout) begin
            res_d.data = SAT_HI;
            res_d.sat  = 1'b1;
          end else if (mode == MODE_SUB && !raw_cout) begin
            res_d.data = SAT_LO;
            res_d.sat  = 1'b1;
          end
        end
      end
      res_d.zero = (res_d.data == '0);
      acc_d      = res_d.data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= INIT;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign acc       = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q.data;
  assign out_cout  = res_q.cout;
  assign out_ovf   = res_q.ovf;
  assign out_zero  = res_q.zero;
  assign out_sat   = res_q.sat;

endmodule

// File: tb/tb_addsub_acc.sv
// Directed bench: one wrapping (SAT=0) and one saturating (SAT=1) instance
// driven by identical commands, each checked against hand-computed results.
module tb_addsub_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] b;
  logic       mode;
  logic       clr;
  logic       out_ready;

  logic       w_in_ready, w_out_valid, w_cout, w_ovf, w_zero, w_sat;
  logic [3:0] w_acc, w_data;
  logic       s_in_ready, s_out_valid, s_cout, s_ovf, s_zero, s_sat;
  logic [3:0] s_acc, s_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_acc #(.INIT(4'h0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .b(b), .mode(mode), .clr(clr), .acc(w_acc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_data),
    .out_cout(w_cout), .out_ovf(w_ovf), .out_zero(w_zero), .out_sat(w_sat)
  );

  addsub_acc #(.INIT(4'h0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .b(b), .mode(mode), .clr(clr), .acc(s_acc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_data),
    .out_cout(s_cout), .out_ovf(s_ovf), .out_zero(s_zero), .out_sat(s_sat)
  );

  typedef struct {
    logic       clr;
    logic       mode;
    logic [3:0] b;
    logic [3:0] w_data;
    logic       w_cout;
    logic       w_ovf;
    logic       w_sat;
    logic [3:0] s_data;
    logic       s_cout;
    logic       s_ovf;
    logic       s_sat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full check of both instances' output registers against one expected result each.
  task automatic check_both(input string tag,
                            input logic [3:0] wd, input logic wc, input logic wo, input logic ws,
                            input logic [3:0] sd, input logic sc, input logic so, input logic ss,
                            input logic vld);
    check({tag, " w.valid"}, {7'd0, w_out_valid}, {7'd0, vld});
    check({tag, " w.data"},  {4'd0, w_data}, {4'd0, wd});
    check({tag, " w.acc"},   {4'd0, w_acc},  {4'd0, wd});
    check({tag, " w.cout"},  {7'd0, w_cout}, {7'd0, wc});
    check({tag, " w.ovf"},   {7'd0, w_ovf},  {7'd0, wo});
    check({tag, " w.zero"},  {7'd0, w_zero}, {7'd0, (wd == 4'h0) && vld});
    check({tag, " w.sat"},   {7'd0, w_sat},  {7'd0, ws});
    check({tag, " s.valid"}, {7'd0, s_out_valid}, {7'd0, vld});
    check({tag, " s.data"},  {4'd0, s_data}, {4'd0, sd});
    check({tag, " s.acc"},   {4'd0, s_acc},  {4'd0, sd});
    check({tag, " s.cout"},  {7'd0, s_cout}, {7'd0, sc});
    check({tag, " s.ovf"},   {7'd0, s_ovf},  {7'd0, so});
    check({tag, " s.zero"},  {7'd0, s_zero}, {7'd0, (sd == 4'h0) && vld});
    check({tag, " s.sat"},   {7'd0, s_sat},  {7'd0, ss});
  endtask

  task automatic drive(input logic v, input logic c, input logic m, input logic [3:0] bb);
    in_valid = v;
    clr      = c;
    mode     = m;
    b        = bb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            clr  mode  b      w_data cout ovf sat   s_data cout ovf sat
    vecs[0]  = '{1'b1, 1'b0, 4'h5,  4'h5, 1'b0, 1'b0, 1'b0,  4'h5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'h3,  4'h8, 1'b0, 1'b1, 1'b0,  4'h8, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h8,  4'h0, 1'b1, 1'b0, 1'b0,  4'h0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'hC,  4'hC, 1'b0, 1'b0, 1'b0,  4'hC, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h6,  4'h2, 1'b1, 1'b0, 1'b0,  4'hF, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 4'h2,  4'h2, 1'b0, 1'b0, 1'b0,  4'h2, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'h5,  4'hD, 1'b0, 1'b0, 1'b0,  4'h0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'h7,  4'h7, 1'b0, 1'b0, 1'b0,  4'h7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'h1,  4'h8, 1'b0, 1'b1, 1'b0,  4'h8, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'h1,  4'h7, 1'b1, 1'b1, 1'b0,  4'h7, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'h0,  4'h0, 1'b0, 1'b0, 1'b0,  4'h0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'h0,  4'h0, 1'b1, 1'b0, 1'b0,  4'h0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'hF,  4'hF, 1'b0, 1'b0, 1'b0,  4'hF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'h1,  4'h0, 1'b1, 1'b0, 1'b0,  4'hF, 1'b1, 1'b0, 1'b1};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    #12;
    check_both("reset", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset in_ready", {6'd0, w_in_ready, s_in_ready}, 8'h03);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table: out_ready stays high, one command per cycle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].clr, vecs[i].mode, vecs[i].b);
      check($sformatf("vec%0d in_ready", i), {6'd0, w_in_ready, s_in_ready}, 8'h03);
      tick();
      check_both($sformatf("vec%0d", i),
                 vecs[i].w_data, vecs[i].w_cout, vecs[i].w_ovf, vecs[i].w_sat,
                 vecs[i].s_data, vecs[i].s_cout, vecs[i].s_ovf, vecs[i].s_sat, 1'b1);
    end

    // Backpressure: load 9, then stall an add of 1 for three cycles.
    drive(1'b1, 1'b1, 1'b0, 4'h9);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d in_ready", i), {6'd0, w_in_ready, s_in_ready}, 8'h00);
      tick();
      check_both($sformatf("stall%0d", i), 4'h9, 1'b0, 1'b0, 1'b0,
                 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", {6'd0, w_in_ready, s_in_ready}, 8'h03);
    tick();
    check_both("release", 4'hA, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);

    // Consume without a new command empties the register.
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    check("drain valid", {6'd0, w_out_valid, s_out_valid}, 8'h00);
    check("drain acc held", {w_acc, s_acc}, 8'hAA);
    out_ready = 1'b0;
    #1;
    check("empty in_ready", {6'd0, w_in_ready, s_in_ready}, 8'h03);

    // Asynchronous reset between edges while a result is pending.
    drive(1'b1, 1'b1, 1'b0, 4'h9);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    check("pre-rst acc", {w_acc, s_acc}, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    check_both("async rst", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'hA);
    tick();
    check_both("post rst", 4'hA, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_acc.md
# addsub_acc

Registered 4-bit accumulator that drives the `adder_sub` adder/subtractor and consumes its sum and carry-out. Each accepted command either loads the accumulator or adds/subtracts an operand to it, with optional unsigned saturation. The result and its flags go to a one-entry valid/ready output register. The block sits directly downstream of the adder/subtractor datapath and turns it into a handshaked, stateful arithmetic stage.

## Interface
- `INIT`, 4'h0, accumulator value after reset.
- `SAT`, 0, 1 = unsigned saturation of results; 0 = modulo-16 wrap.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  command accepted this cycle when high with `in_valid`.
- `b`  in  4  operand.
- `mode`  in  1  0 = add (`acc+b`), 1 = subtract (`acc-b`).
- `clr`  in  1  1 = load `b` into the accumulator; `mode` is ignored.
- `acc`  out  4  current accumulator value.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream takes the result.
- `out_data`  out  4  result value, equal to the new `acc`.
- `out_cout`  out  1  raw carry-out from the adder; in subtract mode it means no borrow (`acc>=b`).
- `out_ovf`  out  1  two's-complement overflow of the raw result.
- `out_zero`  out  1  `out_data == 0`.
- `out_sat`  out  1  saturation was applied to this result.

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and has no dependency on `in_valid`.
- On accept, `clr=1`:
  - `acc` and `out_data` take `b`.
  - `out_cout`, `out_ovf` and `out_sat` are 0.
  - `out_zero = (b==0)`.
- On accept, `clr=0`:
  - The adder is driven with `a=acc`, `b=b`, `mode=mode`.
  - Raw result `r = out`, carry `c = cout`.
  - Add: `ovf = (acc[3]==b[3]) && (r[3]!=acc[3])`.
  - Sub: `ovf = (acc[3]!=b[3]) && (r[3]!=acc[3])`.
  - With `SAT=1`, add with `c=1` gives 4'hF; sub with `c=0` gives 4'h0. `out_sat` is 1 when either substitution occurs, otherwise 0.
  - With `SAT=0`, the result is `r` and `out_sat=0`.
  - The final value is written to both `acc` and `out_data`. Flags are registered with it.
  - `out_ovf` and `out_cout` always describe the raw result, before saturation.
- `out_valid` update:
  - Set on accept.
  - Cleared when `out_valid && out_ready` with no accept in the same cycle.
  - Accept and consume in the same cycle: `out_valid` stays 1 and the register holds the new result.
- With no accept, `acc` and all `out_*` registers hold their values.
- Control is an implicit two-state machine:
  - EMPTY (`out_valid=0`) goes to FULL on accept.
  - FULL goes to EMPTY on consume without accept.
  - FULL stays FULL on consume with accept.
  - FULL stays FULL while `out_ready=0`, and then `in_ready=0`.

## Timing
- Reset values (asynchronous, immediate):
  - `acc=INIT`.
  - `out_valid=0`, `out_data=0`.
  - `out_cout=0`, `out_ovf=0`, `out_zero=0`, `out_sat=0`.
- Reset asserted mid-operation discards any pending result. The first accept is possible on the first rising edge after deassertion.
- Latency: a command accepted at edge N shows its result on `out_*` and `acc` after edge N.
- Throughput: one command per cycle while `out_ready=1`.
- Stall behaviour: with `out_valid=1` and `out_ready=0`, `in_ready=0` and the held command is not consumed. `out_*` must stay stable until consumed.
- The adder path is purely combinational between the `acc` register and the result registers. There is no extra pipeline stage.

## Structure
- Shared package `addsub_pkg`:
  - `MODE_ADD=1'b0`, `MODE_SUB=1'b1`.
  - `DW=4`.
  - `localparam` for saturation limits 4'hF / 4'h0.
- One sub-module instance: `adder_sub` (existing 4-bit ripple adder/subtractor). Its `a` input is `acc`, its `b` input is `b`, and its `mode` input is `mode`.
- Flag logic, saturation mux and handshake logic are inline in `addsub_acc`.

## Test plan
- Reset with `INIT=0`, then accept `clr=1, b=5` → next cycle `out_valid=1`, `out_data=5`, `acc=5`, `cout=0`, `ovf=0`, `zero=0`, `sat=0`.
- From `acc=5`, add `b=3` → `out_data=8`, `cout=0`, `ovf=1`, `zero=0`. Then sub `b=8` → `out_data=0`, `cout=1`, `ovf=0`, `zero=1`.
- `SAT=1`, `acc=C`:
  - Add `b=6` → raw 2 with `cout=1`; `out_data=F`, `sat=1`, `cout=1`.
  - Load 2, then sub `b=5` → raw D with `cout=0`; `out_data=0`, `sat=1`, `zero=1`.
- `SAT=0`, `acc=C`, add `b=6` → `out_data=2`, `cout=1`, `ovf=0`, `sat=0`.
- Backpressure:
  - With `out_valid=1`, hold `out_ready=0` for 3 cycles while `in_valid=1` (add `b=1`) → `in_ready=0`; `acc` and `out_*` unchanged.
  - Raise `out_ready` → accepted that cycle, new result on the next cycle.
  - With continuous `out_ready=1`, back-to-back commands produce one result per cycle.
- Assert `rst` asynchronously between edges while `out_valid=1`, `acc=9` → immediately `out_valid=0`, `acc=INIT`, all flags 0. After release, accept `clr=1, b=A` → `out_data=A`.
